// File: rtl/led_lifetime_ctrl.sv
// Whack-a-LED lifetime controller: lights requested LEDs, expires or clears them.
// Define LED_FLASH_WARN_EN to flash each LED during the last quarter of its life.
module led_lifetime_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int NUM_LEDS   = 18,
  parameter int MAX_ACTIVE = 4,
  parameter int LIFE_EASY  = 2000,
  parameter int LIFE_MED   = 1200,
  parameter int LIFE_HARD  = 700
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          led_index,
  input  logic                led_request,
  input  logic [1:0]          level,
  input  logic [NUM_LEDS-1:0] hit_mask,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                req_drop,
  output logic                hit_pulse,
  output logic                miss_pulse,
  output logic [7:0]          miss_count,
  output logic [2:0]          active_count
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LM1  = (LIFE_EASY > LIFE_MED) ? LIFE_EASY : LIFE_MED;
  localparam int LMAX = (LM1 > LIFE_HARD) ? LM1 : LIFE_HARD;
  localparam int TW   = $clog2(LMAX + 1);
  localparam int CW   = $clog2(NUM_LEDS + 1);

  typedef enum logic {IDLE, LIT} led_st_t;

  led_st_t             state_q [NUM_LEDS];
  led_st_t             state_d [NUM_LEDS];
  logic [TW-1:0]       timer_q [NUM_LEDS];
  logic [TW-1:0]       timer_d [NUM_LEDS];
  logic [PW-1:0]       pre_q;
  logic                tick;
  logic [TW-1:0]       life;
  logic                idx_idle;
  logic                accept;
  logic                hit_any;
  logic [CW-1:0]       miss_k;
  logic [CW-1:0]       lit_n;
  logic [8:0]          miss_sum;
  logic [NUM_LEDS-1:0] lit_d;
  logic [NUM_LEDS-1:0] ledr_d;

`ifdef LED_FLASH_WARN_EN
  localparam int FT = (TICK_HZ / 8 > 1) ? TICK_HZ / 8 : 1;
  localparam int FW = $clog2(FT + 1);

  logic [TW-1:0]       thr_q  [NUM_LEDS];
  logic [TW-1:0]       thr_d  [NUM_LEDS];
  logic [FW-1:0]       fcnt_q [NUM_LEDS];
  logic [FW-1:0]       fcnt_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] warn_q, warn_d;
  logic [NUM_LEDS-1:0] flash_q, flash_d;
`endif

  assign tick = (pre_q == PW'(DIV - 1));

  always_comb begin
    life = TW'(LIFE_HARD);
    unique case (1'b1)
      level == 2'b00: life = TW'(LIFE_EASY);
      level == 2'b01: life = TW'(LIFE_MED);
      level[1]:       life = TW'(LIFE_HARD);
    endcase
  end

  // Index match also rejects out-of-range requests.
  always_comb begin
    idx_idle = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++)
      if (led_index == 5'(i) && state_q[i] == IDLE)
        idx_idle = 1'b1;
  end

  assign accept = led_request && idx_idle &&
                  (int'(active_count) < MAX_ACTIVE);

  always_comb begin
    hit_any = 1'b0;
    miss_k  = '0;
    lit_n   = '0;
    lit_d   = '0;
    ledr_d  = '0;
`ifdef LED_FLASH_WARN_EN
    warn_d  = '0;
    flash_d = flash_q;
`endif
    for (int i = 0; i < NUM_LEDS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
`ifdef LED_FLASH_WARN_EN
      thr_d[i]  = thr_q[i];
      fcnt_d[i] = fcnt_q[i];
`endif
      if (state_q[i] == LIT) begin
        // A hit takes priority over an expiry in the same cycle.
        if (hit_mask[i]) begin
          state_d[i] = IDLE;
          timer_d[i] = '0;
          hit_any    = 1'b1;
        end else if (tick) begin
          if (timer_q[i] == TW'(1)) begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
            miss_k     = miss_k + CW'(1);
          end else begin
            timer_d[i] = timer_q[i] - TW'(1);
          end
        end
      end else if (accept && led_index == 5'(i)) begin
        state_d[i] = LIT;
        timer_d[i] = life;
`ifdef LED_FLASH_WARN_EN
        thr_d[i]   = life >> 2;
`endif
      end
      lit_d[i] = (state_d[i] == LIT);
      lit_n    = lit_n + CW'(lit_d[i]);
`ifdef LED_FLASH_WARN_EN
      warn_d[i] = lit_d[i] && (timer_d[i] <= thr_d[i]);
      if (warn_d[i] && !warn_q[i]) begin
        flash_d[i] = 1'b1;
        fcnt_d[i]  = '0;
      end else if (warn_d[i] && tick) begin
        if (fcnt_q[i] == FW'(FT - 1)) begin
          flash_d[i] = ~flash_q[i];
          fcnt_d[i]  = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + FW'(1);
        end
      end
      ledr_d[i] = lit_d[i] && (!warn_d[i] || flash_d[i]);
`else
      ledr_d[i] = lit_d[i];
`endif
    end
    miss_sum = {1'b0, miss_count} + 9'(miss_k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      LEDR         <= '0;
      req_drop     <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      miss_count   <= '0;
      active_count <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      pre_q        <= tick ? '0 : pre_q + PW'(1);
      LEDR         <= ledr_d;
      req_drop     <= led_request && !accept;
      hit_pulse    <= hit_any;
      miss_pulse   <= (miss_k != '0);
      miss_count   <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
      active_count <= 3'(lit_n);
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

`ifdef LED_FLASH_WARN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      warn_q  <= '0;
      flash_q <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        thr_q[i]  <= '0;
        fcnt_q[i] <= '0;
      end
    end else begin
      warn_q  <= warn_d;
      flash_q <= flash_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        thr_q[i]  <= thr_d[i];
        fcnt_q[i] <= fcnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_led_lifetime_ctrl.sv
// Directed bench for led_lifetime_ctrl with a 10-cycle tick.
// Tracks prescaler phase to place events on exact tick cycles.
module tb_led_lifetime_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  led_index = '0;
  logic        led_request = 1'b0;
  logic [1:0]  level = '0;
  logic [17:0] hit_mask = '0;
  logic [17:0] LEDR;
  logic        req_drop;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [7:0]  miss_count;
  logic [2:0]  active_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_miss = 0;
  int pre_m = 0;

  led_lifetime_ctrl #(
    .CLK_HZ(10000), .TICK_HZ(1000), .NUM_LEDS(18), .MAX_ACTIVE(4),
    .LIFE_EASY(20), .LIFE_MED(12), .LIFE_HARD(7)
  ) dut (
    .clk(clk), .rst(rst), .led_index(led_index),
    .led_request(led_request), .level(level), .hit_mask(hit_mask),
    .LEDR(LEDR), .req_drop(req_drop), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .miss_count(miss_count),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  // Prescaler phase: the cycle with pre_m == 9 is a tick cycle.
  always @(posedge clk)
    if (rst) pre_m <= 0;
    else pre_m <= (pre_m == 9) ? 0 : pre_m + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    rst = 1'b0;
    n_cmp++;
    if (LEDR !== 18'h0) begin
      n_bad++; $display("FAIL reset_ledr got=%h exp=0", LEDR);
    end
    n_cmp++;
    if (active_count !== 3'd0 || miss_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_counts got act=%0d miss=%0d exp 0/0",
               active_count, miss_count);
    end
    n_cmp++;
    if ({req_drop, hit_pulse, miss_pulse} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_pulses got=%b exp=000",
               {req_drop, hit_pulse, miss_pulse});
    end
  endtask

  task automatic test_expiry;
    int n;
    level = 2'b00; led_index = 5'd5; led_request = 1'b1;
    step;
    led_request = 1'b0;
    n_cmp++;
    if (LEDR !== 18'h00020) begin
      n_bad++; $display("FAIL expiry_lit got=%h exp=00020", LEDR);
    end
    n_cmp++;
    if (active_count !== 3'd1) begin
      n_bad++; $display("FAIL expiry_act got=%0d exp=1", active_count);
    end
    n = 0;
    while (LEDR[5] && n < 300) begin step; n++; end
    exp_miss = 1;
    n_cmp++;
    if (n < 191 || n > 200) begin
      n_bad++; $display("FAIL expiry_len got=%0d exp=191..200", n);
    end
    n_cmp++;
    if (miss_pulse !== 1'b1 || miss_count !== 8'(exp_miss)) begin
      n_bad++;
      $display("FAIL expiry_miss got pulse=%b cnt=%0d exp 1/%0d",
               miss_pulse, miss_count, exp_miss);
    end
    step;
    n_cmp++;
    if (miss_pulse !== 1'b0 || active_count !== 3'd0) begin
      n_bad++;
      $display("FAIL expiry_after got pulse=%b act=%0d exp 0/0",
               miss_pulse, active_count);
    end
  endtask

  task automatic test_hit;
    level = 2'b10; led_index = 5'd3; led_request = 1'b1;
    step;
    led_request = 1'b0;
    repeat (29) step;
    hit_mask = 18'h00008;
    led_request = 1'b1;
    step;
    hit_mask = '0;
    led_request = 1'b0;
    n_cmp++;
    if (LEDR !== 18'h0 || hit_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL hit_clear got ledr=%h hit=%b exp 0/1", LEDR, hit_pulse);
    end
    n_cmp++;
    if (req_drop !== 1'b1) begin
      n_bad++; $display("FAIL hit_req_same got=%b exp=1", req_drop);
    end
    n_cmp++;
    if (miss_count !== 8'(exp_miss) || active_count !== 3'd0) begin
      n_bad++;
      $display("FAIL hit_counts got miss=%0d act=%0d exp %0d/0",
               miss_count, active_count, exp_miss);
    end
    step;
    n_cmp++;
    if (hit_pulse !== 1'b0) begin
      n_bad++; $display("FAIL hit_pulse_len got=%b exp=0", hit_pulse);
    end
  endtask

  task automatic test_capacity;
    level = 2'b00;
    for (int i = 0; i < 5; i++) begin
      led_index = 5'(i); led_request = 1'b1;
      step;
    end
    led_request = 1'b0;
    n_cmp++;
    if (req_drop !== 1'b1 || LEDR !== 18'h0000F) begin
      n_bad++;
      $display("FAIL cap_full got drop=%b ledr=%h exp 1/0000F",
               req_drop, LEDR);
    end
    n_cmp++;
    if (active_count !== 3'd4) begin
      n_bad++; $display("FAIL cap_act got=%0d exp=4", active_count);
    end
    hit_mask = '1;
    step;
    hit_mask = '0;
    n_cmp++;
    if (LEDR !== 18'h0 || hit_pulse !== 1'b1 || active_count !== 3'd0) begin
      n_bad++;
      $display("FAIL cap_clear got ledr=%h hit=%b act=%0d exp 0/1/0",
               LEDR, hit_pulse, active_count);
    end
    led_index = 5'd7; led_request = 1'b1;
    step;
    n_cmp++;
    if (req_drop !== 1'b0) begin
      n_bad++; $display("FAIL dup_first got=%b exp=0", req_drop);
    end
    step;
    led_request = 1'b0;
    n_cmp++;
    if (req_drop !== 1'b1 || LEDR !== 18'h00080) begin
      n_bad++;
      $display("FAIL dup_second got drop=%b ledr=%h exp 1/00080",
               req_drop, LEDR);
    end
    led_index = 5'd20; led_request = 1'b1;
    step;
    led_request = 1'b0;
    n_cmp++;
    if (req_drop !== 1'b1 || LEDR !== 18'h00080 || active_count !== 3'd1) begin
      n_bad++;
      $display("FAIL range_drop got drop=%b ledr=%h act=%0d exp 1/00080/1",
               req_drop, LEDR, active_count);
    end
    hit_mask = 18'h00080;
    step;
    hit_mask = '0;
  endtask

  task automatic test_double_miss;
    int n;
    level = 2'b01;
    n = 0;
    while (pre_m != 1 && n < 20) begin step; n++; end
    led_index = 5'd10; led_request = 1'b1;
    step;
    led_index = 5'd11;
    step;
    led_request = 1'b0;
    n_cmp++;
    if (LEDR !== 18'h00C00) begin
      n_bad++; $display("FAIL dbl_lit got=%h exp=00C00", LEDR);
    end
    n = 0;
    while (LEDR === 18'h00C00 && n < 200) begin step; n++; end
    exp_miss += 2;
    n_cmp++;
    if (LEDR !== 18'h0 || miss_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL dbl_expire got ledr=%h pulse=%b exp 0/1",
               LEDR, miss_pulse);
    end
    n_cmp++;
    if (miss_count !== 8'(exp_miss)) begin
      n_bad++; $display("FAIL dbl_count got=%0d exp=%0d", miss_count, exp_miss);
    end
    step;
    n_cmp++;
    if (miss_pulse !== 1'b0) begin
      n_bad++; $display("FAIL dbl_pulse_len got=%b exp=0", miss_pulse);
    end
  endtask

  task automatic test_hit_on_expiry;
    int t;
    int n;
    level = 2'b10; led_index = 5'd6; led_request = 1'b1;
    step;
    led_request = 1'b0;
    t = 0; n = 0;
    while (t < 7 && n < 100) begin
      if (pre_m == 9) t++;
      if (t < 7) begin step; n++; end
    end
    n_cmp++;
    if (LEDR !== 18'h00040) begin
      n_bad++; $display("FAIL hx_before got=%h exp=00040", LEDR);
    end
    hit_mask = 18'h00040;
    step;
    hit_mask = '0;
    n_cmp++;
    if (LEDR !== 18'h0 || hit_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL hx_hit got ledr=%h hit=%b exp 0/1", LEDR, hit_pulse);
    end
    n_cmp++;
    if (miss_pulse !== 1'b0 || miss_count !== 8'(exp_miss)) begin
      n_bad++;
      $display("FAIL hx_nomiss got pulse=%b cnt=%0d exp 0/%0d",
               miss_pulse, miss_count, exp_miss);
    end
  endtask

  task automatic expire_batch(input int k);
    int n;
    level = 2'b10;
    for (int i = 0; i < k; i++) begin
      led_index = 5'(12 + i); led_request = 1'b1;
      step;
    end
    led_request = 1'b0;
    n = 0;
    while (active_count != 3'd0 && n < 200) begin step; n++; end
    exp_miss = (exp_miss + k > 255) ? 255 : exp_miss + k;
    n_cmp++;
    if (miss_count !== 8'(exp_miss)) begin
      n_bad++;
      $display("FAIL sat_step got=%0d exp=%0d", miss_count, exp_miss);
    end
  endtask

  task automatic test_saturation;
    while (exp_miss < 254)
      expire_batch((254 - exp_miss > 4) ? 4 : 254 - exp_miss);
    expire_batch(2);
    n_cmp++;
    if (miss_count !== 8'd255) begin
      n_bad++; $display("FAIL sat_final got=%0d exp=255", miss_count);
    end
  endtask

  task automatic test_reset_mid;
    level = 2'b00;
    for (int i = 0; i < 3; i++) begin
      led_index = 5'(i); led_request = 1'b1;
      step;
    end
    led_request = 1'b0;
    n_cmp++;
    if (active_count !== 3'd3 || LEDR !== 18'h00007) begin
      n_bad++;
      $display("FAIL rm_before got act=%0d ledr=%h exp 3/00007",
               active_count, LEDR);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_cmp++;
    if (LEDR !== 18'h0 || active_count !== 3'd0) begin
      n_bad++;
      $display("FAIL rm_dark got ledr=%h act=%0d exp 0/0", LEDR, active_count);
    end
    n_cmp++;
    if (miss_count !== 8'd0 || miss_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_miss got cnt=%0d pulse=%b exp 0/0",
               miss_count, miss_pulse);
    end
    step;
    n_cmp++;
    if (LEDR !== 18'h0 || miss_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_after got ledr=%h pulse=%b exp 0/0", LEDR, miss_pulse);
    end
  endtask

  initial begin
    test_reset;
    test_expiry;
    test_hit;
    test_capacity;
    test_double_miss;
    test_hit_on_expiry;
    test_saturation;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
